// File: rtl/risc8_pin_in_pkg.sv
// Shared constants for the risc8 GPIO input path: port width, reset value and counter sizing.
package risc8_pin_in_pkg;

    localparam int unsigned     GPIO_WIDTH       = 32'd8;
    localparam logic [7:0]      GPIO_RESET_VALUE = 8'h00;

    // Counter width able to hold 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 32'd1);
    endfunction

endpackage

// File: rtl/risc8_pin_in_if.sv
// Pad/CPU-side bundle of the GPIO input path; slave = risc8_pin_in, master = SoC/CPU side.
interface risc8_pin_in_if #(
    parameter int unsigned WIDTH = 32'd8
);
    logic [WIDTH-1:0] pad;
    logic [WIDTH-1:0] pcmsk;
    logic             pcif_clr;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] pin_chg;
    logic             pcif;
    logic             irq;

    modport master (output pad, pcmsk, pcif_clr, input pin, pin_chg, pcif, irq);
    modport slave  (input pad, pcmsk, pcif_clr, output pin, pin_chg, pcif, irq);
endinterface

// File: rtl/risc8_debounce.sv
// One GPIO bit: two-flop synchroniser, optional debounce counter (RISC8_PIN_DEBOUNCE_EN), pin/pin_chg.
module risc8_debounce
    import risc8_pin_in_pkg::*;
#(
`ifdef RISC8_PIN_DEBOUNCE_EN
    parameter int unsigned DEBOUNCE_CYCLES = 32'd16,
`endif
    parameter logic        RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad,
    output logic pin,
    output logic pin_chg,
    output logic chg
);

    logic sync1_r;
    logic sync2_r;
    logic pin_r;
    logic pin_chg_r;
    logic chg_s;

    // Two-flop synchroniser; the only sampler of the asynchronous pad.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= RESET_BIT;
            sync2_r <= RESET_BIT;
        end else begin
            sync1_r <= pad;
            sync2_r <= sync1_r;
        end
    end

`ifdef RISC8_PIN_DEBOUNCE_EN
    localparam int unsigned      CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

    logic [CW-1:0] cnt_r;

    // Change is accepted once the new level has been seen DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        chg_s = 1'b0;
        if ((sync2_r != pin_r) && (cnt_r == LAST)) begin
            chg_s = 1'b1;
        end else begin
            chg_s = 1'b0;
        end
    end

    // Run-length counter of the disagreeing level; never exceeds LAST, so it cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CW{1'b0}};
        end else if ((sync2_r == pin_r) || chg_s) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end
`else
    // Without debounce the stable value simply follows the synchroniser.
    always_comb begin
        chg_s = sync2_r ^ pin_r;
    end
`endif

    // Stable pin value and its one-cycle change pulse, updated together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pin_r     <= RESET_BIT;
            pin_chg_r <= 1'b0;
        end else begin
            pin_r     <= chg_s ? sync2_r : pin_r;
            pin_chg_r <= chg_s;
        end
    end

    assign pin     = pin_r;
    assign pin_chg = pin_chg_r;
    assign chg     = chg_s;

endmodule

// File: rtl/risc8_pin_in.sv
// risc8 GPIO input port: WIDTH debounced pins plus sticky pin-change flag / irq.
// Debounce is built only when RISC8_PIN_DEBOUNCE_EN is defined; otherwise pins follow the synchroniser.
module risc8_pin_in
    import risc8_pin_in_pkg::*;
#(
    parameter int unsigned      WIDTH           = GPIO_WIDTH,
    parameter int unsigned      DEBOUNCE_CYCLES = 32'd16,
    parameter logic [WIDTH-1:0] RESET_VALUE     = WIDTH'(GPIO_RESET_VALUE)
) (
    input  logic           clk,
    input  logic           reset_n,
    risc8_pin_in_if.slave  bus
);

    if ((DEBOUNCE_CYCLES < 32'd1) || (DEBOUNCE_CYCLES > 32'd65535)) begin : g_bad_cycles
        $error("risc8_pin_in: DEBOUNCE_CYCLES must be 1..65535");
    end

    logic [WIDTH-1:0] pin_s;
    logic [WIDTH-1:0] pin_chg_s;
    logic [WIDTH-1:0] chg_s;
    logic             pcif_r;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        risc8_debounce #(
`ifdef RISC8_PIN_DEBOUNCE_EN
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`endif
            .RESET_BIT       (RESET_VALUE[i])
        ) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .pad     (bus.pad[i]),
            .pin     (pin_s[i]),
            .pin_chg (pin_chg_s[i]),
            .chg     (chg_s[i])
        );
    end

    // Sticky flag: a masked change on this edge wins over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcif_r <= 1'b0;
        end else if (|(chg_s & bus.pcmsk)) begin
            pcif_r <= 1'b1;
        end else if (bus.pcif_clr) begin
            pcif_r <= 1'b0;
        end else begin
            pcif_r <= pcif_r;
        end
    end

    assign bus.pin     = pin_s;
    assign bus.pin_chg = pin_chg_s;
    assign bus.pcif    = pcif_r;
    assign bus.irq     = pcif_r;

endmodule

// File: tb/tb_risc8_pin_in.sv
// Randomised bench for risc8_pin_in against a window-based reference model (DEBOUNCE_CYCLES=4, RESET_VALUE=0).
module tb_risc8_pin_in;

`ifdef RISC8_PIN_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 1;
`endif
    localparam logic [7:0] RV = 8'h00;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    risc8_pin_in_if #(.WIDTH(8)) bus ();

    risc8_pin_in #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .RESET_VALUE     (RV)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: pad samples seen since reset, and the level presented to the debouncer per edge.
    logic [7:0] padq[$];
    logic [7:0] cmpq[$];
    logic [7:0] pin_m;
    logic [7:0] chg_m;
    logic       pcif_m;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        padq.delete();
        cmpq.delete();
        padq.push_back(RV);
        padq.push_back(RV);
        pin_m  = RV;
        chg_m  = 8'h00;
        pcif_m = 1'b0;
    endtask

    // A bit takes a new level when the last DB presented levels all differ from the current pin.
    task automatic model_edge();
        logic [7:0] cmp;
        logic [7:0] chg;
        bit         all_new;
        padq.push_back(bus.pad);
        cmp = padq[padq.size() - 3];
        cmpq.push_back(cmp);
        chg = 8'h00;
        if (cmpq.size() >= DB) begin
            for (int i = 0; i < 8; i++) begin
                all_new = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (cmpq[cmpq.size() - 1 - k][i] == pin_m[i]) all_new = 1'b0;
                chg[i] = all_new;
            end
        end
        pin_m = pin_m ^ chg;
        chg_m = chg;
        if (|(chg & bus.pcmsk)) pcif_m = 1'b1;
        else if (bus.pcif_clr) pcif_m = 1'b0;
        if (padq.size() > 16) void'(padq.pop_front());
        if (cmpq.size() > 16) void'(cmpq.pop_front());
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".pin"},     {24'h0, bus.pin},     {24'h0, pin_m});
        check_val({tag, ".pin_chg"}, {24'h0, bus.pin_chg}, {24'h0, chg_m});
        check_val({tag, ".pcif"},    {31'h0, bus.pcif},    {31'h0, pcif_m});
        check_val({tag, ".irq"},     {31'h0, bus.irq},     {31'h0, pcif_m});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic steps(input int n, input string tag);
        for (int j = 0; j < n; j++) step(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any edge.
    task automatic pulse_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all({tag, ".rst"});
        check_val({tag, ".rst_pin_const"}, {24'h0, bus.pin}, {24'h0, RV});
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.pad      = 8'hFF;
        bus.pcmsk    = 8'h01;
        bus.pcif_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        check_val("reset.pcif_const", {31'h0, bus.pcif}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Pads differ from reset value: pin follows after full latency.
        steps(8, "post_reset");

        bus.pcif_clr = 1'b1; step("clr1");
        bus.pcif_clr = 1'b0;
        bus.pad = 8'h00; steps(8, "fall");
        bus.pcif_clr = 1'b1; step("clr2");
        bus.pcif_clr = 1'b0;

        // Short and just-long-enough pulses on bit 0.
        bus.pad = 8'h01; steps(3, "glitch3");
        bus.pad = 8'h00; steps(8, "glitch3_tail");
        bus.pad = 8'h01; steps(4, "pulse4");
        bus.pad = 8'h00; steps(8, "pulse4_tail");
        bus.pad = 8'h01; steps(1, "glitch1");
        bus.pad = 8'h00; steps(8, "glitch1_tail");

        // Masked-off change must not set the flag.
        bus.pcif_clr = 1'b1; step("clr3");
        bus.pcif_clr = 1'b0;
        bus.pcmsk = 8'h00;
        bus.pad = 8'h08; steps(8, "nomask_rise");
        bus.pad = 8'h00; steps(8, "nomask_fall");

        // Clear held across a masked change: set must win on the change edge.
        bus.pcmsk = 8'h20;
        bus.pcif_clr = 1'b1;
        bus.pad = 8'h20; steps(8, "set_wins");
        bus.pcif_clr = 1'b0; steps(2, "hold");
        bus.pcif_clr = 1'b1; step("clr4");
        bus.pcif_clr = 1'b0;
        bus.pcmsk = 8'hFF; steps(2, "mask_only");

        // Reset in the middle of a debounce count.
        bus.pad = 8'h24; steps(2, "midcount");
        pulse_reset("midcount");
        steps(9, "after_rst");

        // Random pad activity, masks, clears and occasional resets.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 4) == 0) bus.pad[i] = ~bus.pad[i];
            if ($urandom_range(0, 15) == 0) bus.pcmsk = 8'($urandom);
            bus.pcif_clr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 199) == 0) pulse_reset("rand");
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/risc8_pin_in.md
Name: risc8_pin_in

Overview:
- Input side of the risc8 SoC GPIO port: the pad-to-CPU path feeding `pin_b`, the counterpart of the `port_b`/`ddr_b` output path.
- Synchronises 8 asynchronous pad inputs and debounces each bit.
- Presents the stable value as the PIN register and raises a sticky pin-change interrupt flag on masked bit changes.
- Instantiated inside risc8_soc between the board pads and the CPU I/O read mux.

Parameters:
- WIDTH, 8, number of pins handled.
- DEBOUNCE_CYCLES, 16, consecutive clock cycles a synchronised input must hold a new level before `pin` takes it; legal range 1..65535.
- RESET_VALUE, 8'h00, reset value of the synchroniser flops and of `pin`.

Ports:
- clk  in  1  system clock; same clock as the CPU.
- reset_n  in  1  asynchronous assert, active-low reset.
- pad  in  WIDTH  raw asynchronous pad inputs.
- pcmsk  in  WIDTH  pin-change mask from the SoC register file; 1 = bit may set the flag.
- pcif_clr  in  1  one-cycle pulse from a CPU write-1 to the flag register; clears `pcif`.
- pin  out  WIDTH  debounced, synchronised pin value (`pin_b` to the CPU).
- pin_chg  out  WIDTH  one-cycle pulse per bit on the edge where that bit of `pin` changes; unmasked.
- pcif  out  1  sticky pin-change interrupt flag.
- irq  out  1  equals `pcif`; level interrupt request to the CPU.

Behaviour:
- Reset (reset_n low, async):
  - both synchroniser stages = RESET_VALUE;
  - `pin` = RESET_VALUE;
  - all debounce counters = 0;
  - `pin_chg` = 0, `pcif` = 0, `irq` = 0.
  - Takes effect immediately and overrides everything, including mid-debounce; a partially counted debounce is discarded.
- Synchroniser: two flops per bit (`sync1`, `sync2`); nothing else samples `pad`.
- Debounce, per bit, counter width clog2(DEBOUNCE_CYCLES+1):
  - `sync2` == `pin[i]`: counter <= 0.
  - `sync2` != `pin[i]` and counter == DEBOUNCE_CYCLES-1: `pin[i]` <= `sync2`, counter <= 0, `pin_chg[i]` = 1 for that cycle.
  - Otherwise: counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES resets the count and never reaches `pin`.
  - Latency: a clean pad step reaches `pin` exactly 2+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
  - Counters saturate by construction; no wrap.
- Pin-change flag (registered):
  - `pcif` <= 1 on any edge where |(`pin_chg` & `pcmsk`); otherwise `pcif` <= 0 when `pcif_clr`; otherwise hold.
  - Simultaneous set and clear: set wins, so no change event is lost.
  - `pcmsk` is sampled on the same edge as the change.
  - Changing `pcmsk` never sets the flag by itself.
- Post-reset: if pads differ from RESET_VALUE, `pin` transitions after the latency above. This is a normal change and sets `pcif` if masked; software clears it at init.
- Multiple bits changing on one edge: one flag set; `pin_chg` shows all changed bits.

Optional Feature:
- Macro: RISC8_PIN_DEBOUNCE_EN.
- Defined: debounce counters as described above.
- Undefined:
  - no counters;
  - `pin` <= `sync2` every cycle;
  - `pin_chg` = `sync2` ^ `pin` (registered with `pin`);
  - pad-to-pin latency is 3 edges;
  - DEBOUNCE_CYCLES is ignored.

Decomposition:
- Shared include risc8_defs.vh: RISC8_GPIO_WIDTH (8), reset-value constant, and the I/O addresses of PINB and PCMSK/PCIF for the SoC decoder.
- One sub-module, risc8_debounce: single-bit synchroniser plus counter plus `pin`/`pin_chg` outputs, parameterised by DEBOUNCE_CYCLES and reset bit.
- The top generates WIDTH instances and holds the `pcif` logic.

Test Plan (DEBOUNCE_CYCLES=4, RESET_VALUE=0, feature enabled unless noted):
1. Hold reset_n=0 with pad=8'hFF, then release with pcmsk=8'h01 -> `pin`=8'h00 for 5 edges, becomes 8'hFF on edge 6; `pin_chg`=8'hFF for one cycle; `pcif`=1 on the same edge.
2. pad[0] 0->1 pulse of 3 cycles -> `pin` stays 8'h00, `pin_chg` stays 0, `pcif` stays 0. Repeat with a 4-cycle pulse -> `pin[0]` rises on the 6th edge after the pulse starts.
3. pcmsk=8'h00, toggle pad[3] cleanly -> `pin[3]` follows, `pin_chg[3]` pulses, `pcif` stays 0.
4. `pcif`=1, assert `pcif_clr` on the same edge a masked bit changes -> `pcif` stays 1. Next `pcif_clr` with no change -> `pcif`=0.
5. pad[2] rising, reset_n pulsed low mid-count (cycle 2 of debounce) -> `pin`=0 and `pcif`=0 immediately. After release, full 6-edge latency applies again.
6. RISC8_PIN_DEBOUNCE_EN undefined, 1-cycle pad[1] pulse aligned to the clock -> `pin[1]` high for exactly 1 cycle, 3 edges later.
